btn_counter_display: RTL
========================

Name: btn_counter_display

Overview:
Board-level modulo counter driven by push-buttons and switches, shown on a multiplexed multi-digit 7-segment display. It generalises the earlier two-digit, hard-wired block in four ways:
- per-button synchronisation and debouncing;
- up/down counting with a parametrised wrap value;
- decimal or hexadecimal display mode;
- N-digit scanning with leading-zero blanking.

It sits directly under the board top level, between the raw btn/sw pins and the anode/cathode/led pins.

Parameters:
CNT_W, 8, counter and switch width (bits).
MOD_MAX, 47, terminal count value; MOD_MAX < 2^CNT_W.
NUM_DIGITS, 4, number of 7-segment digits scanned. Must be enough to show MOD_MAX in decimal and in hex.
REFRESH_DIV, 250000, clk cycles each digit is lit before the scan advances.
DB_CYCLES, 500000, clk cycles a synchronised button level must be stable before it is accepted; minimum 2.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset, synchronous, active-high.
btn  in  3  raw asynchronous buttons: [0]=increment, [1]=load, [2]=decrement.
sw  in  CNT_W  load value.
hex_mode  in  1  1 = hexadecimal display, 0 = decimal display.
count  out  CNT_W  current counter value.
led  out  4  low nibble of the last value loaded.
anodes  out  NUM_DIGITS  digit enables, active-low.
cathodes  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - count=0, led=0;
  - synchronisers, debounce counters, stable button levels = 0;
  - refresh counter = 0, digit index = 0;
  - anodes all-ones, cathodes 7'b1111111;
  - digit registers = all-zero value; any conversion in flight is aborted.
- Synchronisation: each btn bit passes through 2 flops (s1, s2).
- Debounce, per button:
  - While s2 == stable, the counter is held at 0.
  - While s2 != stable, the counter increments each cycle.
  - When the counter reaches DB_CYCLES-1 with s2 still != stable: stable <= s2, counter <= 0.
  - Glitches shorter than DB_CYCLES cycles are ignored.
- Press event: one-cycle pulse when stable goes 0->1. Release events do nothing.
- Latency: raw rise just before edge 1 → stable=1 at edge DB_CYCLES+2 → count updated at edge DB_CYCLES+3.
- A button held through reset deasserting is reported as one press after debouncing.
- Count update, in priority order on a pulse cycle:
  - load pulse: count <= min(sw, MOD_MAX); led <= sw[3:0] (unclamped).
  - inc and dec pulses in the same cycle: no change.
  - inc: MOD_MAX → 0, otherwise +1.
  - dec: 0 → MOD_MAX, otherwise -1.
  - load together with inc/dec: load wins.
- Digit generation, re-run whenever count or hex_mode changes:
  - Hex mode: digit i = count[4i+3:4i]; bits beyond CNT_W read as 0. Digit registers update 1 cycle after the change.
  - Decimal mode: sequential shift-and-add-3 (double-dabble) converter, CNT_W cycles. Digit registers update CNT_W+1 cycles after the change.
  - A change mid-conversion restarts the conversion.
  - Digit registers hold their old value until the conversion completes.
- Leading-zero blanking: digit i (i>0) is blank (7'b1111111) when it and every higher digit are 0. Digit 0 is always shown.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1. Its wrap is the tick.
  - On each tick: index advances (NUM_DIGITS-1 → 0), anodes <= ~(1<<index_new), cathodes <= pattern for that digit. Both are registered.
  - The first tick after reset lights digit 1. Digit 0 is first lit at tick NUM_DIGITS.
- Segment table, active-low gfedcba:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Exactly one anode is low after the first tick.

Test Plan:
Bench parameters for all scenarios: DB_CYCLES=4, REFRESH_DIV=8, CNT_W=8, MOD_MAX=47, NUM_DIGITS=4.
1. Load and decimal display: reset, sw=45, hex_mode=0, hold btn[1] 20 cycles → count=45 exactly at edge 7; led=4'hD. After conversion the scan gives:
   - anodes 1110 → cathodes 0010010;
   - anodes 1101 → cathodes 0011001;
   - anodes 1011 and 0111 → cathodes 1111111.
2. Wrap and direction: from 45, three clean btn[0] presses → 46, 47, 0; one btn[2] press → 47; another btn[2] press → 46.
3. Bounce rejection: btn[0] toggled high 3 cycles / low 2 cycles ×10 → count unchanged. Then held 12 cycles → count +1 exactly once.
4. Clamp and simultaneous events:
   - sw=200 with load → count=47, led=4'h8.
   - btn[0] and btn[2] rising together → count unchanged.
   - btn[1] and btn[0] together, sw=3 → count=3.
5. Hex mode and mid-conversion change:
   - count=47, hex_mode=1 → digit0 0001110 (F), digit1 0100100 (2), digits 2–3 blank.
   - Switch to hex_mode=0 and press inc mid-conversion → display settles to 0,0 shown as digit0 1000000, higher digits blank.
6. Reset mid-operation: assert rst for 1 cycle during a debounce count and a decimal conversion → count=0, led=0, anodes 1111, cathodes 1111111 on the next edge. A btn[0] held across reset yields one press, and count=1.

Source files
------------

// File: rtl/btn_counter_display.sv
// Push-button modulo counter shown on a scanned N-digit 7-segment display.
// Buttons are synchronised and debounced, and the display can show decimal or hex.
module btn_counter_display #(
   parameter int CNT_W       = 8,
   parameter int MOD_MAX     = 47,
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 250000,
   parameter int DB_CYCLES   = 500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            btn,
   input  logic [CNT_W-1:0]      sw,
   input  logic                  hex_mode,
   output logic [CNT_W-1:0]      count,
   output logic [3:0]            led,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic [6:0]            cathodes
);

   localparam int DBW   = $clog2(DB_CYCLES);
   localparam int RFW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDXW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int BITW  = $clog2(CNT_W + 1);

   localparam logic [CNT_W-1:0] MOD_VAL = CNT_W'(MOD_MAX);

   localparam logic [0:0] CONV_IDLE = 1'b0;
   localparam logic [0:0] CONV_RUN  = 1'b1;

   logic [2:0]     sync1;
   logic [2:0]     sync2;
   logic [2:0]     stable;
   logic [2:0]     stable_d;
   logic [2:0]     press;
   logic [DBW-1:0] db_cnt [3];

   logic [CNT_W-1:0] count_seen;
   logic             mode_seen;
   logic             change;
   logic [BCD_W-1:0] hex_digits;
   logic [0:0]       conv_state;
   logic [CNT_W-1:0] bin_sh;
   logic [CNT_W-1:0] bin_next;
   logic [BCD_W-1:0] bcd;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W-1:0] bcd_next;
   logic [BITW-1:0]  bit_cnt;
   logic [BCD_W-1:0] digits;

   logic [NUM_DIGITS-1:0] blank;
   logic                  any_nz;
   logic [RFW-1:0]        refresh_cnt;
   logic                  tick;
   logic [IDXW-1:0]       digit_idx;
   logic [IDXW-1:0]       idx_next;
   logic [3:0]            sel_digit;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // A button level is only accepted once the synchronised input has disagreed
   // with the accepted level for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = stable & ~stable_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         led   <= '0;
      end else if (press[1]) begin
         count <= (sw > MOD_VAL) ? MOD_VAL : sw;
         led   <= sw[3:0];
      end else if (press[0] && !press[2]) begin
         count <= (count == MOD_VAL) ? '0 : count + 1'b1;
      end else if (press[2] && !press[0]) begin
         count <= (count == '0) ? MOD_VAL : count - 1'b1;
      end
   end

   assign change     = (count != count_seen) || (hex_mode != mode_seen);
   assign hex_digits = BCD_W'(count);

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd_next = (bcd_adj << 1) | BCD_W'(bin_sh[CNT_W-1]);
      bin_next = bin_sh << 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_seen <= '0;
         mode_seen  <= 1'b0;
         conv_state <= CONV_IDLE;
         bin_sh     <= '0;
         bcd        <= '0;
         bit_cnt    <= '0;
         digits     <= '0;
      end else begin
         count_seen <= count;
         mode_seen  <= hex_mode;
         if (change) begin
            if (hex_mode) begin
               digits     <= hex_digits;
               conv_state <= CONV_IDLE;
            end else begin
               bin_sh     <= count;
               bcd        <= '0;
               bit_cnt    <= '0;
               conv_state <= CONV_RUN;
            end
         end else if (conv_state == CONV_RUN) begin
            bin_sh <= bin_next;
            bcd    <= bcd_next;
            if (bit_cnt == BITW'(CNT_W - 1)) begin
               digits     <= bcd_next;
               conv_state <= CONV_IDLE;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   // Walk down from the top digit; a digit is blank until a non-zero digit has been seen.
   always_comb begin
      blank  = '0;
      any_nz = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         any_nz   = any_nz | (digits[i*4 +: 4] != 4'd0);
         blank[i] = !any_nz;
      end
   end

   assign tick      = (refresh_cnt == RFW'(REFRESH_DIV - 1));
   assign idx_next  = (digit_idx == IDXW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
   assign sel_digit = digits[{idx_next, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
         anodes      <= '1;
         cathodes    <= 7'b1111111;
      end else if (tick) begin
         refresh_cnt <= '0;
         digit_idx   <= idx_next;
         anodes      <= ~(NUM_DIGITS'(1) << idx_next);
         cathodes    <= blank[idx_next] ? 7'b1111111 : seg7(sel_digit);
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

endmodule
